frame_bank_switcher: RTL and testbench

Parametrised N-bank frame buffer switcher between the gumstix write port and the LED read port. It generalises the fixed two-RAM cross exchange to 2 or 3 external SRAM banks, with configurable address and data widths. Bank roles rotate only at frame boundaries, under a writer/reader handshake, so the reader never sees a torn frame. All bank pins are registered on the falling clock edge.

---
 rtl/frame_bank_switcher_pkg.sv | 14 +
 rtl/fbs_bank_port.sv | 50 +++++
 rtl/frame_bank_switcher.sv | 149 ++++++++++++++
 tb/tb_frame_bank_switcher.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/frame_bank_switcher_pkg.sv
// Shared types and constants for the frame bank switcher.
// Bank roles, index width and swap counter width live here.
package frame_bank_switcher_pkg;

  typedef enum logic [1:0] {
    ROLE_WRITE = 2'd0,
    ROLE_READ  = 2'd1,
    ROLE_SPARE = 2'd2
  } bank_role_t;

  localparam int BANK_IDX_W = 2;
  localparam int SWAP_CNT_W = 16;

endpackage

// File: rtl/fbs_bank_port.sv
// Falling-edge pin register for one external SRAM bank.
// The role decides whether the bank follows the writer, the reader or parks.
module fbs_bank_port
  import frame_bank_switcher_pkg::*;
#(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        role,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_wdata,
  input  logic              wr_we_n,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W-1:0] bank_addr,
  output logic [DATA_W-1:0] bank_wdata,
  output logic              bank_we_n,
  output logic              bank_oe_n
);

  // A spare bank keeps its last address so its pins stay quiet between frames.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      bank_addr  <= '0;
      bank_wdata <= '0;
      bank_we_n  <= 1'b1;
      bank_oe_n  <= 1'b1;
    end else begin
      bank_wdata <= wr_wdata;
      case (bank_role_t'(role))
        ROLE_WRITE: begin
          bank_addr <= wr_addr;
          bank_we_n <= wr_we_n;
          bank_oe_n <= 1'b1;
        end
        ROLE_READ: begin
          bank_addr <= rd_addr;
          bank_we_n <= 1'b1;
          bank_oe_n <= 1'b0;
        end
        default: begin
          bank_we_n <= 1'b1;
          bank_oe_n <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/frame_bank_switcher.sv
// N-bank (2 or 3) frame buffer switcher between the gumstix writer and LED reader.
// Define FRAME_BANK_SWITCHER_SWAP_COUNT_EN to add the swap_count port and counter.
module frame_bank_switcher
  import frame_bank_switcher_pkg::*;
#(
  parameter int NUM_BANKS = 2,
  parameter int ADDR_W    = 19,
  parameter int DATA_W    = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [ADDR_W-1:0]           wr_addr,
  input  logic [DATA_W-1:0]           wr_wdata,
  input  logic                        wr_we_n,
  input  logic                        wr_frame_done,
  output logic                        wr_ready,
  input  logic [ADDR_W-1:0]           rd_addr,
  output logic [DATA_W-1:0]           rd_data,
  input  logic                        rd_frame_start,
  output logic [1:0]                  rd_bank,
  output logic [NUM_BANKS*ADDR_W-1:0] bank_addr,
  output logic [NUM_BANKS*DATA_W-1:0] bank_wdata,
  input  logic [NUM_BANKS*DATA_W-1:0] bank_rdata,
  output logic [NUM_BANKS-1:0]        bank_we_n,
  output logic [NUM_BANKS-1:0]        bank_oe_n
`ifdef FRAME_BANK_SWITCHER_SWAP_COUNT_EN
  ,
  output logic [SWAP_CNT_W-1:0]       swap_count
`endif
);

  logic [BANK_IDX_W-1:0] wr_idx, rd_idx, sp_idx;
  logic [BANK_IDX_W-1:0] wr_idx_n, rd_idx_n, sp_idx_n;
  logic [BANK_IDX_W-1:0] rd_sel_q;
  logic                  rdy, rdy_n, wr_ready_n;
  logic                  frame_done_ok;
  logic                  wr_we_gated;
  logic [DATA_W-1:0]     rd_mux;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_idx   <= BANK_IDX_W'(0);
      rd_idx   <= BANK_IDX_W'(1);
      sp_idx   <= BANK_IDX_W'(2);
      rdy      <= 1'b0;
      wr_ready <= 1'b1;
    end else begin
      wr_idx   <= wr_idx_n;
      rd_idx   <= rd_idx_n;
      sp_idx   <= sp_idx_n;
      rdy      <= rdy_n;
      wr_ready <= wr_ready_n;
    end
  end

  // Roles only rotate at frame boundaries; the reader never sees a half-written bank.
  always_comb begin
    wr_idx_n      = wr_idx;
    rd_idx_n      = rd_idx;
    sp_idx_n      = sp_idx;
    rdy_n         = rdy;
    wr_ready_n    = wr_ready;
    frame_done_ok = wr_frame_done & wr_ready;
    if (NUM_BANKS == 2) begin
      if (rd_frame_start && (rdy || frame_done_ok)) begin
        wr_idx_n   = rd_idx;
        rd_idx_n   = wr_idx;
        rdy_n      = 1'b0;
        wr_ready_n = 1'b1;
      end else if (frame_done_ok) begin
        rdy_n      = 1'b1;
        wr_ready_n = 1'b0;
      end
    end else begin
      wr_ready_n = 1'b1;
      if (wr_frame_done && rd_frame_start) begin
        rd_idx_n = wr_idx;
        wr_idx_n = rd_idx;
        rdy_n    = 1'b0;
      end else if (wr_frame_done) begin
        // Newest frame wins: an unread frame in the spare is overwritten.
        wr_idx_n = sp_idx;
        sp_idx_n = wr_idx;
        rdy_n    = 1'b1;
      end else if (rd_frame_start && rdy) begin
        rd_idx_n = sp_idx;
        sp_idx_n = rd_idx;
        rdy_n    = 1'b0;
      end
    end
  end

  assign rd_bank     = rd_idx;
  assign wr_we_gated = wr_we_n | ~wr_ready;

  for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
    bank_role_t role;

    always_comb begin
      if (rd_idx == BANK_IDX_W'(i))      role = ROLE_READ;
      else if (sp_idx == BANK_IDX_W'(i)) role = ROLE_SPARE;
      else                               role = ROLE_WRITE;
    end

    fbs_bank_port #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W)
    ) u_port (
      .clk       (clk),
      .rst       (rst),
      .role      (role),
      .wr_addr   (wr_addr),
      .wr_wdata  (wr_wdata),
      .wr_we_n   (wr_we_gated),
      .rd_addr   (rd_addr),
      .bank_addr (bank_addr[i*ADDR_W +: ADDR_W]),
      .bank_wdata(bank_wdata[i*DATA_W +: DATA_W]),
      .bank_we_n (bank_we_n[i]),
      .bank_oe_n (bank_oe_n[i])
    );
  end

  // The read index travels with the address so a swap cannot redirect returning data.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) rd_sel_q <= BANK_IDX_W'(1);
    else     rd_sel_q <= rd_idx;
  end

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (rd_sel_q == BANK_IDX_W'(i)) rd_mux = bank_rdata[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data <= '0;
    else     rd_data <= rd_mux;
  end

`ifdef FRAME_BANK_SWITCHER_SWAP_COUNT_EN
  // Every change of the reader index is exactly one reader swap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     swap_count <= '0;
    else if (rd_idx_n != rd_idx) swap_count <= swap_count + SWAP_CNT_W'(1);
  end
`endif

endmodule

// File: tb/tb_frame_bank_switcher.sv
// Directed bench for frame_bank_switcher: a 2-bank and a 3-bank instance share
// clock, reset and data inputs; each has its own frame handshake pulses.
module tb_frame_bank_switcher;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [18:0] wr_addr = '0;
  logic [7:0]  wr_wdata = '0;
  logic        wr_we_n = 1'b1;
  logic [18:0] rd_addr = '0;

  logic        wr_frame_done2 = 1'b0, rd_frame_start2 = 1'b0;
  logic        wr_frame_done3 = 1'b0, rd_frame_start3 = 1'b0;

  logic        wr_ready2, wr_ready3;
  logic [7:0]  rd_data2, rd_data3;
  logic [1:0]  rd_bank2, rd_bank3;
  logic [37:0] bank_addr2;
  logic [56:0] bank_addr3;
  logic [15:0] bank_wdata2;
  logic [23:0] bank_wdata3;
  logic [15:0] bank_rdata2 = 16'h3C11;
  logic [23:0] bank_rdata3 = 24'h424140;
  logic [1:0]  bank_we_n2, bank_oe_n2;
  logic [2:0]  bank_we_n3, bank_oe_n3;
`ifdef FRAME_BANK_SWITCHER_SWAP_COUNT_EN
  logic [15:0] swap_count2, swap_count3;
`endif

  int num_checks = 0;
  int num_fails  = 0;

  always #5 clk = ~clk;

  frame_bank_switcher #(.NUM_BANKS(2), .ADDR_W(19), .DATA_W(8)) dut2 (
    .clk(clk), .rst(rst),
    .wr_addr(wr_addr), .wr_wdata(wr_wdata), .wr_we_n(wr_we_n),
    .wr_frame_done(wr_frame_done2), .wr_ready(wr_ready2),
    .rd_addr(rd_addr), .rd_data(rd_data2), .rd_frame_start(rd_frame_start2),
    .rd_bank(rd_bank2),
`ifdef FRAME_BANK_SWITCHER_SWAP_COUNT_EN
    .swap_count(swap_count2),
`endif
    .bank_addr(bank_addr2), .bank_wdata(bank_wdata2), .bank_rdata(bank_rdata2),
    .bank_we_n(bank_we_n2), .bank_oe_n(bank_oe_n2)
  );

  frame_bank_switcher #(.NUM_BANKS(3), .ADDR_W(19), .DATA_W(8)) dut3 (
    .clk(clk), .rst(rst),
    .wr_addr(wr_addr), .wr_wdata(wr_wdata), .wr_we_n(wr_we_n),
    .wr_frame_done(wr_frame_done3), .wr_ready(wr_ready3),
    .rd_addr(rd_addr), .rd_data(rd_data3), .rd_frame_start(rd_frame_start3),
    .rd_bank(rd_bank3),
`ifdef FRAME_BANK_SWITCHER_SWAP_COUNT_EN
    .swap_count(swap_count3),
`endif
    .bank_addr(bank_addr3), .bank_wdata(bank_wdata3), .bank_rdata(bank_rdata3),
    .bank_we_n(bank_we_n3), .bank_oe_n(bank_oe_n3)
  );

  // Drive one cycle of inputs just after the rising edge.
  task automatic applyStimulus(input logic fd2, input logic fs2, input logic fd3,
                               input logic fs3, input logic we_n);
    @(posedge clk);
    #1;
    wr_frame_done2  = fd2;
    rd_frame_start2 = fs2;
    wr_frame_done3  = fd3;
    rd_frame_start3 = fs3;
    wr_we_n         = we_n;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    num_checks++;
    assert (observed === expected) else begin
      num_fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic afterNegedge();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] starting frame_bank_switcher bench");
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst2_we_n", bank_we_n2, 2'b11);
    checkOutput("rst2_oe_n", bank_oe_n2, 2'b11);
    checkOutput("rst2_wr_ready", wr_ready2, 1'b1);
    checkOutput("rst2_rd_bank", rd_bank2, 2'd1);
    checkOutput("rst2_rd_data", rd_data2, 8'h00);
    checkOutput("rst3_oe_n", bank_oe_n3, 3'b111);
    rst = 1'b0;

    // 2-bank write to bank 0 and read from bank 1
    wr_addr  = 19'h00010;
    wr_wdata = 8'hA5;
    rd_addr  = 19'h00020;
    applyStimulus(0, 0, 0, 0, 0);
    afterNegedge();
    checkOutput("wr_we_n_b0", bank_we_n2, 2'b10);
    checkOutput("wr_addr_b0", bank_addr2[18:0], 19'h00010);
    checkOutput("rd_addr_b1", bank_addr2[37:19], 19'h00020);
    checkOutput("wr_wdata_b0", bank_wdata2[7:0], 8'hA5);
    checkOutput("oe_n_b1", bank_oe_n2, 2'b01);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("rd_data_b1", rd_data2, 8'h3C);

    // 2-bank handshake: frame done blocks writes until the reader swaps
    applyStimulus(1, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("hs_wr_ready_low", wr_ready2, 1'b0);
    checkOutput("hs_rd_bank_hold", rd_bank2, 2'd1);
    afterNegedge();
    checkOutput("hs_write_blocked", bank_we_n2, 2'b11);
    applyStimulus(0, 1, 0, 0, 0);
    afterNegedge();
    checkOutput("hs_write_blocked2", bank_we_n2, 2'b11);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("hs_rd_bank_swap", rd_bank2, 2'd0);
    checkOutput("hs_wr_ready_high", wr_ready2, 1'b1);
    afterNegedge();
    checkOutput("hs_write_b1", bank_we_n2, 2'b01);
    checkOutput("hs_oe_b0", bank_oe_n2, 2'b10);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("hs_rd_data_b0", rd_data2, 8'h11);

    // 2-bank simultaneous done/start swaps at once, writer never stalls
    applyStimulus(1, 1, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("same_rd_bank", rd_bank2, 2'd1);
    checkOutput("same_wr_ready", wr_ready2, 1'b1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("same_wr_ready2", wr_ready2, 1'b1);
`ifdef FRAME_BANK_SWITCHER_SWAP_COUNT_EN
    checkOutput("swap_count2", swap_count2, 16'd2);
`endif

    // 2-bank reset mid-frame with a pending swap
    applyStimulus(1, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("mid2_pending", wr_ready2, 1'b0);
    #2 rst = 1'b1;
    #1;
    checkOutput("mid2_wr_ready", wr_ready2, 1'b1);
    checkOutput("mid2_rd_bank", rd_bank2, 2'd1);
`ifdef FRAME_BANK_SWITCHER_SWAP_COUNT_EN
    checkOutput("mid2_swap_count", swap_count2, 16'd0);
`endif
    rst = 1'b0;
    applyStimulus(0, 1, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("mid2_no_swap", rd_bank2, 2'd1);
    checkOutput("mid2_wr_ready2", wr_ready2, 1'b1);

    // 3-bank: fresh reset
    rst = 1'b1;
    #2;
    checkOutput("rst3_rd_bank", rd_bank3, 2'd1);
    checkOutput("rst3_wr_ready", wr_ready3, 1'b1);
    checkOutput("rst3_rd_data", rd_data3, 8'h00);
    checkOutput("rst3_we_n", bank_we_n3, 3'b111);
    rst = 1'b0;

    // Two frame-done pulses with no reader swap: writer returns to bank 0
    applyStimulus(0, 0, 1, 0, 1);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("tb3_wr_ready", wr_ready3, 1'b1);
    afterNegedge();
    checkOutput("tb3_write_b2", bank_we_n3, 3'b011);
    checkOutput("tb3_oe_b1", bank_oe_n3, 3'b101);
    applyStimulus(0, 0, 1, 0, 1);
    applyStimulus(0, 0, 0, 0, 0);
    afterNegedge();
    checkOutput("tb3_write_b0", bank_we_n3, 3'b110);

    // Reader picks up the newest frame in bank 2
    applyStimulus(0, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("tb3_rd_bank_new", rd_bank3, 2'd2);
    afterNegedge();
    checkOutput("tb3_oe_b2", bank_oe_n3, 3'b011);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("tb3_rd_data_b2", rd_data3, 8'h42);

    // Frame start with nothing ready leaves the reader alone
    applyStimulus(0, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("tb3_no_ready", rd_bank3, 2'd2);

    // Simultaneous: reader takes writer bank 0, writer takes bank 2
    applyStimulus(0, 0, 1, 1, 1);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("tb3_same_rd", rd_bank3, 2'd0);
    afterNegedge();
    checkOutput("tb3_same_wr_b2", bank_we_n3, 3'b011);

    // Third reader swap: writer 2->1, spare 1->2, then reader 0->2
    applyStimulus(0, 0, 1, 0, 1);
    applyStimulus(0, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("tb3_third_swap", rd_bank3, 2'd2);
`ifdef FRAME_BANK_SWITCHER_SWAP_COUNT_EN
    checkOutput("swap_count3", swap_count3, 16'd3);
`endif

    // 3-bank reset mid-frame with rdy set
    applyStimulus(0, 0, 1, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("mid3_rd_bank", rd_bank3, 2'd1);
`ifdef FRAME_BANK_SWITCHER_SWAP_COUNT_EN
    checkOutput("mid3_swap_count", swap_count3, 16'd0);
`endif
    rst = 1'b0;
    applyStimulus(0, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("mid3_no_swap", rd_bank3, 2'd1);
    afterNegedge();
    checkOutput("mid3_oe_b1", bank_oe_n3, 3'b101);

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule
